// File: rtl/pixel_window_gen.sv
// Raster-to-3x3-window generator: two line buffers plus a two-column shift
// window, emitting one edge-replicated neighbourhood per frame pixel.
module pixel_window_gen #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] s_pixel,
  input  logic        s_valid,
  input  logic        s_sof,
  output logic        s_ready,
  output logic [23:0] pixel_out,
  output logic [23:0] pixel_left,
  output logic [23:0] pixel_right,
  output logic [23:0] pixel_top,
  output logic [23:0] pixel_bottom,
  output logic [23:0] pixel_tl,
  output logic [23:0] pixel_tr,
  output logic [23:0] pixel_bl,
  output logic [23:0] pixel_br,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        valid_out
);

  localparam int unsigned PW = 24;
  localparam int unsigned CW = 10;
  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_nxt;

  // lb_a holds the previous input line, lb_b the one before it
  logic [PW-1:0] lb_a [WIDTH];
  logic [PW-1:0] lb_b [WIDTH];

  // input raster position and centre (output) raster position
  logic [XW-1:0] ix, cx;
  logic [YW-1:0] iy, cy;

  // column registers: c0 = most recent column (window centre), c1 = the one before
  // each column holds rows {new = iy, mid = iy-1, old = iy-2} at its x
  logic [PW-1:0] c0_new, c0_mid, c0_old;
  logic [PW-1:0] c1_new, c1_mid, c1_old;

  logic          accept, take_sof, adv, emit, last_beat, flush_done, ready_nxt;
  logic          col_load, lb_we;
  logic [XW-1:0] lb_idx;
  logic [PW-1:0] n_new, n_mid, n_old;
  logic [PW-1:0] ln, lm, lo, rn, rm, ro;
  logic          left_edge, right_edge, top_edge, bot_edge;
  logic [PW-1:0] w_c, w_l, w_r, w_t, w_b, w_tl, w_tr, w_bl, w_br;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take_sof)   state_nxt = RUN;
      RUN:     if (last_beat)  state_nxt = FLUSH;
      FLUSH:   if (flush_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // control decode: beat acceptance, frame start, emission strobes
  always_comb begin
    accept     = s_valid && s_ready;
    take_sof   = 1'b0;
    adv        = 1'b0;
    emit       = 1'b0;
    flush_done = 1'b0;
    case (state)
      IDLE: take_sof = accept && s_sof;
      RUN: begin
        take_sof = accept && s_sof;
        adv      = accept && !s_sof;
        emit     = adv && ((iy > YW'(1)) || ((iy == YW'(1)) && (ix != '0)));
      end
      FLUSH: begin
        emit       = 1'b1;
        flush_done = (cx == X_LAST) && (cy == Y_LAST);
      end
      default: ;
    endcase
    last_beat = adv && (ix == X_LAST) && (iy == Y_LAST);
    col_load  = take_sof || adv || (state == FLUSH);
    lb_we     = take_sof || adv;
    ready_nxt = (state_nxt != FLUSH);
  end

  // incoming column and clamped 3x3 window around the centre column c0
  always_comb begin
    lb_idx = take_sof ? '0 : ix;
    n_mid  = lb_a[lb_idx];
    n_old  = lb_b[lb_idx];
    // during flush there is no new line; the bottom row is always replicated then
    n_new  = (state == FLUSH) ? n_mid : s_pixel;

    left_edge  = (cx == '0);
    right_edge = (cx == X_LAST);
    top_edge   = (cy == '0);
    bot_edge   = (cy == Y_LAST);

    ln = left_edge ? c0_new : c1_new;
    lm = left_edge ? c0_mid : c1_mid;
    lo = left_edge ? c0_old : c1_old;
    rn = right_edge ? c0_new : n_new;
    rm = right_edge ? c0_mid : n_mid;
    ro = right_edge ? c0_old : n_old;

    w_c  = c0_mid;
    w_l  = lm;
    w_r  = rm;
    w_t  = top_edge ? c0_mid : c0_old;
    w_b  = bot_edge ? c0_mid : c0_new;
    w_tl = top_edge ? lm : lo;
    w_tr = top_edge ? rm : ro;
    w_bl = bot_edge ? lm : ln;
    w_br = bot_edge ? rm : rn;
  end

  // line buffers: shift the column at lb_idx down one line
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb_b[lb_idx] <= lb_a[lb_idx];
      lb_a[lb_idx] <= s_pixel;
    end
  end

  // column shift window and raster counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c0_new <= '0; c0_mid <= '0; c0_old <= '0;
      c1_new <= '0; c1_mid <= '0; c1_old <= '0;
      ix <= '0; iy <= '0; cx <= '0; cy <= '0;
    end else begin
      if (col_load) begin
        c1_new <= c0_new; c1_mid <= c0_mid; c1_old <= c0_old;
        c0_new <= n_new;  c0_mid <= n_mid;  c0_old <= n_old;
      end
      if (take_sof) begin
        ix <= XW'(1);
        iy <= '0;
        cx <= '0;
        cy <= '0;
      end else begin
        if (adv || (state == FLUSH)) begin
          if (ix == X_LAST) begin
            ix <= '0;
            iy <= (iy == Y_LAST) ? '0 : iy + 1'b1;
          end else begin
            ix <= ix + 1'b1;
          end
        end
        if (emit) begin
          if (cx == X_LAST) begin
            cx <= '0;
            cy <= (cy == Y_LAST) ? '0 : cy + 1'b1;
          end else begin
            cx <= cx + 1'b1;
          end
        end
      end
    end
  end

  // registered window outputs and handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_ready      <= 1'b1;
      valid_out    <= 1'b0;
      pixel_out    <= '0;
      pixel_left   <= '0;
      pixel_right  <= '0;
      pixel_top    <= '0;
      pixel_bottom <= '0;
      pixel_tl     <= '0;
      pixel_tr     <= '0;
      pixel_bl     <= '0;
      pixel_br     <= '0;
      x            <= '0;
      y            <= '0;
    end else begin
      s_ready   <= ready_nxt;
      valid_out <= emit;
      if (emit) begin
        pixel_out    <= w_c;
        pixel_left   <= w_l;
        pixel_right  <= w_r;
        pixel_top    <= w_t;
        pixel_bottom <= w_b;
        pixel_tl     <= w_tl;
        pixel_tr     <= w_tr;
        pixel_bl     <= w_bl;
        pixel_br     <= w_br;
        x            <= CW'(cx);
        y            <= CW'(cy);
      end
    end
  end

endmodule

// File: tb/tb_pixel_window_gen.sv
// Randomised self-checking bench for pixel_window_gen (4x3 frame).
module tb_pixel_window_gen;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] s_pixel = '0;
  logic        s_valid = 1'b0;
  logic        s_sof = 1'b0;
  logic        s_ready, valid_out;
  logic [23:0] pixel_out, pixel_left, pixel_right, pixel_top, pixel_bottom;
  logic [23:0] pixel_tl, pixel_tr, pixel_bl, pixel_br;
  logic [9:0]  x, y;

  typedef struct packed {
    logic [9:0]       x;
    logic [9:0]       y;
    logic [8:0][23:0] w;  // c, l, r, t, b, tl, tr, bl, br
  } win_t;

  win_t        obs_q[$];
  logic [23:0] img [H][W];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  pixel_window_gen #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .s_pixel(s_pixel), .s_valid(s_valid), .s_sof(s_sof),
    .s_ready(s_ready), .pixel_out(pixel_out), .pixel_left(pixel_left),
    .pixel_right(pixel_right), .pixel_top(pixel_top), .pixel_bottom(pixel_bottom),
    .pixel_tl(pixel_tl), .pixel_tr(pixel_tr), .pixel_bl(pixel_bl), .pixel_br(pixel_br),
    .x(x), .y(y), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  function automatic win_t cur_win();
    win_t e;
    e.x = x; e.y = y;
    e.w[0] = pixel_out;  e.w[1] = pixel_left; e.w[2] = pixel_right;
    e.w[3] = pixel_top;  e.w[4] = pixel_bottom;
    e.w[5] = pixel_tl;   e.w[6] = pixel_tr;   e.w[7] = pixel_bl; e.w[8] = pixel_br;
    return e;
  endfunction

  // reference: neighbourhood of (xx,yy) in img with coordinates clamped into the frame
  function automatic win_t exp_win(input int xx, input int yy);
    win_t e;
    int xl, xr, yt, yb;
    xl = (xx > 0) ? xx - 1 : 0;
    xr = (xx < W - 1) ? xx + 1 : W - 1;
    yt = (yy > 0) ? yy - 1 : 0;
    yb = (yy < H - 1) ? yy + 1 : H - 1;
    e.x = 10'(xx); e.y = 10'(yy);
    e.w[0] = img[yy][xx]; e.w[1] = img[yy][xl]; e.w[2] = img[yy][xr];
    e.w[3] = img[yt][xx]; e.w[4] = img[yb][xx];
    e.w[5] = img[yt][xl]; e.w[6] = img[yt][xr];
    e.w[7] = img[yb][xl]; e.w[8] = img[yb][xr];
    return e;
  endfunction

  function automatic win_t mk_win(input int xx, input int yy,
                                  input logic [23:0] c, l, r, t, b, tl, tr, bl, br);
    win_t e;
    e.x = 10'(xx); e.y = 10'(yy);
    e.w[0] = c; e.w[1] = l; e.w[2] = r; e.w[3] = t; e.w[4] = b;
    e.w[5] = tl; e.w[6] = tr; e.w[7] = bl; e.w[8] = br;
    return e;
  endfunction

  task automatic fill_plan();
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        img[yy][xx] = {16'h0, 4'(yy), 4'(xx)};
  endtask

  task automatic fill_random();
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        img[yy][xx] = 24'($urandom);
  endtask

  // collect every window the DUT presents
  always @(negedge clk) if (valid_out) obs_q.push_back(cur_win());

  // present one beat at a negedge, hold it across one posedge; returns at the next negedge
  task automatic send(input logic [23:0] p, input logic sof);
    int g = 0;
    while (!s_ready && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) begin
      total_cnt++;
      $display("FAIL send_timeout: s_ready=%b required 1", s_ready);
    end
    s_pixel = p; s_sof = sof; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (!s_ready && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) begin
      total_cnt++;
      $display("FAIL idle_timeout: s_ready=%b required 1", s_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    total_cnt++; if (s_ready !== 1'b1) $display("FAIL reset_ready: got %b exp 1", s_ready); else pass_cnt++;
    total_cnt++; if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b exp 0", valid_out); else pass_cnt++;
    total_cnt++; if (cur_win() !== win_t'(0)) $display("FAIL reset_window: got %h exp 0", cur_win()); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_plan_frame();
    win_t e0, el;
    int lo;
    fill_plan();
    obs_q.delete();
    e0 = mk_win(0, 0, 24'h00, 24'h00, 24'h01, 24'h00, 24'h10, 24'h00, 24'h01, 24'h10, 24'h11);
    el = mk_win(3, 2, 24'h23, 24'h22, 24'h23, 24'h13, 24'h23, 24'h12, 24'h13, 24'h22, 24'h23);
    for (int n = 0; n < N; n++) begin
      send(img[n / W][n % W], n == 0);
      total_cnt++;
      if (valid_out !== (n >= W + 1))
        $display("FAIL plan_valid idx %0d: got %b exp %b", n, valid_out, n >= W + 1);
      else pass_cnt++;
      if (n == W + 1) begin
        total_cnt++;
        if (cur_win() !== e0) $display("FAIL plan_first_win: got %h exp %h", cur_win(), e0);
        else pass_cnt++;
      end
    end
    lo = 0;
    while (!s_ready && lo < 50) begin lo++; @(negedge clk); end
    total_cnt++; if (lo != W + 1) $display("FAIL plan_flush_len: got %0d exp %0d", lo, W + 1); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (obs_q.size() != N) $display("FAIL plan_pulses: got %0d exp %0d", obs_q.size(), N); else pass_cnt++;
    total_cnt++; if (obs_q[N-1] !== el) $display("FAIL plan_last_win: got %h exp %h", obs_q[N-1], el); else pass_cnt++;
    for (int i = 0; i < obs_q.size() && i < N; i++) begin
      total_cnt++;
      if (obs_q[i] !== exp_win(i % W, i / W))
        $display("FAIL plan_win %0d: got %h exp %h", i, obs_q[i], exp_win(i % W, i / W));
      else pass_cnt++;
    end
  endtask

  task automatic test_random_gaps();
    fill_random();
    obs_q.delete();
    for (int n = 0; n < N; n++) begin
      send(img[n / W][n % W], n == 0);
      if (n < N - 1) begin
        int g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) begin
          s_pixel = 24'($urandom);
          @(negedge clk);
          total_cnt++;
          if (valid_out !== 1'b0) $display("FAIL gap_valid idx %0d: got %b exp 0", n, valid_out);
          else pass_cnt++;
        end
      end
    end
    wait_idle();
    total_cnt++; if (obs_q.size() != N) $display("FAIL gap_pulses: got %0d exp %0d", obs_q.size(), N); else pass_cnt++;
    for (int i = 0; i < obs_q.size() && i < N; i++) begin
      total_cnt++;
      if (obs_q[i] !== exp_win(i % W, i / W))
        $display("FAIL gap_win %0d: got %h exp %h", i, obs_q[i], exp_win(i % W, i / W));
      else pass_cnt++;
    end
  endtask

  task automatic test_pre_sof();
    obs_q.delete();
    for (int k = 0; k < 6; k++) begin
      send(24'($urandom), 1'b0);
      total_cnt++;
      if (valid_out !== 1'b0 || s_ready !== 1'b1)
        $display("FAIL presof_beat %0d: valid=%b ready=%b exp valid 0 ready 1", k, valid_out, s_ready);
      else pass_cnt++;
    end
    fill_random();
    for (int n = 0; n < N; n++) send(img[n / W][n % W], n == 0);
    wait_idle();
    total_cnt++; if (obs_q.size() != N) $display("FAIL presof_pulses: got %0d exp %0d", obs_q.size(), N); else pass_cnt++;
    for (int i = 0; i < obs_q.size() && i < N; i++) begin
      total_cnt++;
      if (obs_q[i] !== exp_win(i % W, i / W))
        $display("FAIL presof_win %0d: got %h exp %h", i, obs_q[i], exp_win(i % W, i / W));
      else pass_cnt++;
    end
  endtask

  task automatic test_abort();
    win_t ea0, ea1;
    obs_q.delete();
    fill_random();
    for (int n = 0; n < 7; n++) send(img[n / W][n % W], n == 0);
    ea0 = exp_win(0, 0);
    ea1 = exp_win(1, 0);
    fill_random();
    for (int n = 0; n < N; n++) begin
      send(img[n / W][n % W], n == 0);
      total_cnt++;
      if (valid_out !== (n >= W + 1))
        $display("FAIL abort_valid idx %0d: got %b exp %b", n, valid_out, n >= W + 1);
      else pass_cnt++;
      if (n == W + 1) begin
        total_cnt++;
        if (cur_win() !== exp_win(0, 0)) $display("FAIL abort_first_win: got %h exp %h", cur_win(), exp_win(0, 0));
        else pass_cnt++;
      end
    end
    wait_idle();
    total_cnt++; if (obs_q.size() != N + 2) $display("FAIL abort_pulses: got %0d exp %0d", obs_q.size(), N + 2); else pass_cnt++;
    total_cnt++; if (obs_q[0] !== ea0) $display("FAIL abort_old0: got %h exp %h", obs_q[0], ea0); else pass_cnt++;
    total_cnt++; if (obs_q[1] !== ea1) $display("FAIL abort_old1: got %h exp %h", obs_q[1], ea1); else pass_cnt++;
    for (int i = 2; i < obs_q.size() && i < N + 2; i++) begin
      total_cnt++;
      if (obs_q[i] !== exp_win((i - 2) % W, (i - 2) / W))
        $display("FAIL abort_win %0d: got %h exp %h", i - 2, obs_q[i], exp_win((i - 2) % W, (i - 2) / W));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_flush();
    fill_random();
    for (int n = 0; n < N; n++) send(img[n / W][n % W], n == 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total_cnt++; if (valid_out !== 1'b0) $display("FAIL rstflush_valid: got %b exp 0", valid_out); else pass_cnt++;
    total_cnt++; if (s_ready !== 1'b1) $display("FAIL rstflush_ready: got %b exp 1", s_ready); else pass_cnt++;
    total_cnt++; if (cur_win() !== win_t'(0)) $display("FAIL rstflush_window: got %h exp 0", cur_win()); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    obs_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total_cnt++;
      if (valid_out !== 1'b0) $display("FAIL rstflush_after %0d: got %b exp 0", k, valid_out);
      else pass_cnt++;
    end
    fill_random();
    for (int n = 0; n < N; n++) send(img[n / W][n % W], n == 0);
    wait_idle();
    total_cnt++; if (obs_q.size() != N) $display("FAIL rstflush_pulses: got %0d exp %0d", obs_q.size(), N); else pass_cnt++;
    for (int i = 0; i < obs_q.size() && i < N; i++) begin
      total_cnt++;
      if (obs_q[i] !== exp_win(i % W, i / W))
        $display("FAIL rstflush_win %0d: got %h exp %h", i, obs_q[i], exp_win(i % W, i / W));
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_plan_frame();
    test_random_gaps();
    test_random_gaps();
    test_pre_sof();
    test_abort();
    test_reset_flush();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pixel_window_gen.md
# pixel_window_gen

Raster-to-window generator feeding the 3x3 neighbourhood filters (Gaussian blur and later kernels). Accepts one 24-bit RGB pixel per beat in raster order, buffers two lines internally, and emits for every frame pixel the centre plus its eight neighbours with edge replication, tagged with its (x, y) coordinate and a one-cycle valid strobe. It is the producer side of the filter's `pixel_in` / neighbour / `valid_in` interface.

## Interface
- `WIDTH`, 640: active pixels per line; 2..1024.
- `HEIGHT`, 480: active lines per frame; 2..1024.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `s_pixel`  in  24  input pixel, {R[23:16], G[15:8], B[7:0]}.
- `s_valid`  in  1  input beat present.
- `s_sof`  in  1  start of frame; qualifies the beat carrying pixel (0,0).
- `s_ready`  out  1  block can accept a beat; a beat transfers when `s_valid && s_ready`.
- `pixel_out`  out  24  centre pixel (x, y).
- `pixel_left`, `pixel_right`, `pixel_top`, `pixel_bottom`  out  24 each  (x-1,y), (x+1,y), (x,y-1), (x,y+1).
- `pixel_tl`, `pixel_tr`, `pixel_bl`, `pixel_br`  out  24 each  (x-1,y-1), (x+1,y-1), (x-1,y+1), (x+1,y+1).
- `x`, `y`  out  10 each  coordinate of the centre pixel.
- `valid_out`  out  1  one-cycle strobe; all window outputs and x/y valid while high.

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE: `s_ready`=1; accepted beats without `s_sof` are discarded. An accepted beat with `s_sof` is taken as input index 0 and moves to RUN.
- RUN: `s_ready`=1; each accepted beat advances input index n (raster, n = iy*WIDTH+ix). When input index n >= WIDTH+1 is accepted, the window for output index n-(WIDTH+1) is emitted. Accepting index WIDTH*HEIGHT-1 (last pixel) moves to FLUSH.
- FLUSH: `s_ready`=0; emits the remaining WIDTH+1 windows on consecutive cycles with no input, then returns to IDLE.
- `s_sof` on an accepted beat in RUN: abort current frame without flush; the beat becomes index 0 of a new frame; emission restarts after WIDTH+1 further beats.
- Edge replication: out-of-frame coordinates clamp to the nearest in-frame pixel (x-1 at x=0 -> x; x+1 at x=WIDTH-1 -> x; same for y). Corners clamp both axes. No data from another line or frame ever appears in a window.
- Output order strictly raster, exactly WIDTH*HEIGHT `valid_out` pulses per completed frame; x wraps WIDTH-1 -> 0 with y+1.
- Line buffers: two WIDTH x 24 stores; contents are don't-care after reset or abort.
- No downstream backpressure; consumer must take every `valid_out` beat.

## Timing
- Reset values: state IDLE, `s_ready`=1, `valid_out`=0, all pixel outputs 24'h000000, `x`=`y`=0.
- Latency: `valid_out` for output index m asserts the cycle after input index m+WIDTH+1 is accepted (registered outputs).
- Input gaps (`s_valid`=0) stall emission; outputs hold last values, `valid_out`=0.
- FLUSH: first flushed window the cycle after the last-pixel accept; WIDTH+1 back-to-back pulses; IDLE (`s_ready`=1) the cycle after the final flushed pulse.
- `s_ready` is a function of state only (no combinational path from `s_valid`).
- Reset mid-frame: all outputs return to reset values asynchronously; no partial windows emitted after release.

## Test plan
- WIDTH=4, HEIGHT=3, pixel value = {16'h0, y,x nibbles} (e.g. (2,1) -> 24'h000012), continuous valid -> first `valid_out` one cycle after index 5 accepted: x=0,y=0, centre 00, left 00, right 01, top 00, bottom 10, tl 00, tr 01, bl 10, br 11.
- Same frame, last output (3,2): centre 23, left 22, right 23, top 13, bottom 23, tl 12, tr 13, bl 22, br 23; `s_ready` low exactly 5 cycles after last accept; 12 pulses total.
- Random `s_valid` gaps across full frame -> window contents identical to continuous case; no `valid_out` during gaps before FLUSH.
- Beats before any `s_sof` -> discarded, no `valid_out`; then `s_sof` frame processes normally.
- `s_sof` at input index 7 mid-frame -> no flush, next emitted window is x=0,y=0 of the new frame after 5 more beats.
- Assert `rst` low during FLUSH -> `valid_out`=0 and `s_ready`=1 immediately; next frame after release produces correct (0,0) window.
